// File: rtl/contador_duzias_if.sv
// Bottle-counter bus: approval pulse and swap handshake in, count/status/display out.
// master = line controller / box handler side, slave = contador_duzias.
interface contador_duzias_if;
    logic       INCREMENTA_DUZIA;
    logic       CAIXA_TROCADA;
    logic [3:0] CONTAGEM_GARRAFAS;
    logic       CAIXA_COMPLETA;
    logic       PARAR_ESTEIRA;
    logic [1:0] PENDENTES;
    logic [3:0] TOTAL_DEZ;
    logic [3:0] TOTAL_UNI;
    logic       ERRO_PERDA;

    modport master (
        output INCREMENTA_DUZIA,
        output CAIXA_TROCADA,
        input  CONTAGEM_GARRAFAS,
        input  CAIXA_COMPLETA,
        input  PARAR_ESTEIRA,
        input  PENDENTES,
        input  TOTAL_DEZ,
        input  TOTAL_UNI,
        input  ERRO_PERDA
    );

    modport slave (
        input  INCREMENTA_DUZIA,
        input  CAIXA_TROCADA,
        output CONTAGEM_GARRAFAS,
        output CAIXA_COMPLETA,
        output PARAR_ESTEIRA,
        output PENDENTES,
        output TOTAL_DEZ,
        output TOTAL_UNI,
        output ERRO_PERDA
    );
endinterface

// File: rtl/contador_duzias.sv
// Packing-end bottle counter with box-swap handshake and two-digit BCD box total.
// Define FILA_ESPERA_EN to queue bottles approved during a swap (otherwise they are lost).
module contador_duzias #(
    parameter int GARRAFAS_POR_CAIXA = 12,
    parameter int PENDENTES_MAX      = 3
) (
    input  logic CLOCK,
    input  logic RESET,
    contador_duzias_if.slave barramento
);

`ifdef FILA_ESPERA_EN
    localparam bit FILA_ATIVA = 1'b1;
`else
    localparam bit FILA_ATIVA = 1'b0;
`endif

    localparam logic [3:0] CHEIO    = 4'(GARRAFAS_POR_CAIXA);
    localparam logic [3:0] QUASE    = 4'(GARRAFAS_POR_CAIXA - 1);
    // Queue capacity collapses to zero when the queue is compiled out.
    localparam logic [1:0] FILA_CAP = FILA_ATIVA ? 2'(PENDENTES_MAX) : 2'd0;

    typedef enum logic [1:0] {
        ENCHENDO = 2'b00,
        CHEIA    = 2'b01,
        TROCANDO = 2'b10
    } estado_t;

    estado_t    estado_reg, estado_next;
    logic [3:0] contagem_reg, contagem_next;
    logic [1:0] pendentes_reg, pendentes_next;
    logic [3:0] dez_reg, dez_next;
    logic [3:0] uni_reg, uni_next;
    logic       erro_reg, erro_next;
    logic       caixa_completa, parar_esteira;
    logic       pulso, troca, na_fila;

    assign pulso = barramento.INCREMENTA_DUZIA;
    assign troca = barramento.CAIXA_TROCADA;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            estado_reg <= ENCHENDO;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            ENCHENDO: if (pulso && contagem_reg >= QUASE) estado_next = CHEIA;
            CHEIA:    if (troca)  estado_next = TROCANDO;
            TROCANDO: if (!troca) estado_next = ENCHENDO;
            default:  estado_next = ENCHENDO;
        endcase
    end

    always_comb begin
        caixa_completa = 1'b0;
        parar_esteira  = 1'b0;
        case (estado_reg)
            CHEIA: begin
                caixa_completa = 1'b1;
                parar_esteira  = 1'b1;
            end
            TROCANDO: parar_esteira = 1'b1;
            default: ;
        endcase
    end

    // A pulse in the release cycle goes straight into the new box, not the queue.
    always_comb begin
        contagem_next  = contagem_reg;
        pendentes_next = pendentes_reg;
        dez_next       = dez_reg;
        uni_next       = uni_reg;
        erro_next      = erro_reg;
        na_fila        = 1'b0;
        case (estado_reg)
            ENCHENDO: begin
                if (pulso) begin
                    contagem_next = (contagem_reg >= QUASE) ? CHEIO : contagem_reg + 4'd1;
                end
            end
            CHEIA: begin
                na_fila = pulso;
                if (troca) begin
                    if (uni_reg >= 4'd9) begin
                        uni_next = 4'd0;
                        dez_next = (dez_reg >= 4'd9) ? 4'd0 : dez_reg + 4'd1;
                    end else begin
                        uni_next = uni_reg + 4'd1;
                    end
                end
            end
            TROCANDO: begin
                if (!troca) begin
                    contagem_next  = {2'b00, pendentes_reg} + {3'b000, pulso};
                    pendentes_next = 2'd0;
                end else begin
                    na_fila = pulso;
                end
            end
            default: ;
        endcase
        if (na_fila) begin
            if (pendentes_reg == FILA_CAP) begin
                erro_next = 1'b1;
            end else begin
                pendentes_next = pendentes_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            contagem_reg  <= 4'd0;
            pendentes_reg <= 2'd0;
            dez_reg       <= 4'd0;
            uni_reg       <= 4'd0;
            erro_reg      <= 1'b0;
        end else begin
            contagem_reg  <= contagem_next;
            pendentes_reg <= pendentes_next;
            dez_reg       <= dez_next;
            uni_reg       <= uni_next;
            erro_reg      <= erro_next;
        end
    end

    assign barramento.CONTAGEM_GARRAFAS = contagem_reg;
    assign barramento.CAIXA_COMPLETA    = caixa_completa;
    assign barramento.PARAR_ESTEIRA     = parar_esteira;
    assign barramento.PENDENTES         = pendentes_reg;
    assign barramento.TOTAL_DEZ         = dez_reg;
    assign barramento.TOTAL_UNI         = uni_reg;
    assign barramento.ERRO_PERDA        = erro_reg;

endmodule

// File: tb/tb_contador_duzias.sv
// Self-checking bench for contador_duzias: directed scenarios plus random traffic
// compared against a bottle/box-level reference model.
module tb_contador_duzias;

    localparam int G    = 12;
    localparam int PMAX = 3;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    contador_duzias_if barramento ();

    contador_duzias #(
        .GARRAFAS_POR_CAIXA(G),
        .PENDENTES_MAX(PMAX)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .barramento(barramento.slave)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: phase 0 filling, 1 box full, 2 swapping
    int m_fase;
    int m_cont;
    int m_total;
    int fila[$];
    bit m_erro;

    int n_checks;
    int n_fail;

    function automatic logic [20:0] observado();
        return {barramento.CONTAGEM_GARRAFAS, barramento.CAIXA_COMPLETA,
                barramento.PARAR_ESTEIRA, barramento.PENDENTES,
                barramento.TOTAL_DEZ, barramento.TOTAL_UNI, barramento.ERRO_PERDA,
                4'd0};
    endfunction

    function automatic logic [20:0] esperado();
        logic c, p;
        c = (m_fase == 1);
        p = (m_fase != 0);
        return {4'(m_cont), c, p, 2'(fila.size()),
                4'(m_total / 10), 4'(m_total % 10), m_erro, 4'd0};
    endfunction

    task automatic modelo_reset();
        m_fase  = 0;
        m_cont  = 0;
        m_total = 0;
        fila.delete();
        m_erro  = 1'b0;
    endtask

    task automatic enfileira();
`ifdef FILA_ESPERA_EN
        if (fila.size() < PMAX) fila.push_back(1);
        else m_erro = 1'b1;
`else
        m_erro = 1'b1;
`endif
    endtask

    task automatic passo(input bit p, input bit t);
        @(negedge CLOCK);
        barramento.INCREMENTA_DUZIA = p;
        barramento.CAIXA_TROCADA    = t;
        @(posedge CLOCK);
        case (m_fase)
            0: if (p) begin
                m_cont = m_cont + 1;
                if (m_cont >= G) begin
                    m_cont = G;
                    m_fase = 1;
                end
            end
            1: begin
                if (p) enfileira();
                if (t) begin
                    m_fase  = 2;
                    m_total = (m_total + 1) % 100;
                end
            end
            default: begin
                if (!t) begin
                    m_cont = fila.size() + (p ? 1 : 0);
                    fila.delete();
                    m_fase = 0;
                end else if (p) begin
                    enfileira();
                end
            end
        endcase
        #1;
    endtask

    task automatic aplica_reset();
        @(negedge CLOCK);
        barramento.INCREMENTA_DUZIA = 1'b0;
        barramento.CAIXA_TROCADA    = 1'b0;
        RESET = 1'b1;
        modelo_reset();
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    task automatic enche_caixa();
        for (int i = 0; i < G; i++) passo(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        barramento.INCREMENTA_DUZIA = 1'b0;
        barramento.CAIXA_TROCADA    = 1'b0;
        modelo_reset();
        #2;
        n_checks++;
        if (observado() !== 21'd0) begin
            n_fail++;
            $display("FAIL reset: obtido %h esperado %h", observado(), 21'd0);
        end
        @(negedge CLOCK);
        RESET = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_enchimento();
        aplica_reset();
        for (int i = 0; i < G; i++) begin
            passo(1'b1, 1'b0);
            n_checks++;
            if (barramento.CONTAGEM_GARRAFAS !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL enchimento_contagem: obtido %0d esperado %0d",
                         barramento.CONTAGEM_GARRAFAS, i + 1);
            end
            if (i == G - 1) begin
                n_checks++;
                if ({barramento.CAIXA_COMPLETA, barramento.PARAR_ESTEIRA} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL enchimento_cheia: obtido %b esperado 11",
                             {barramento.CAIXA_COMPLETA, barramento.PARAR_ESTEIRA});
                end
            end else begin
                n_checks++;
                if ({barramento.CAIXA_COMPLETA, barramento.PARAR_ESTEIRA} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL enchimento_parado: obtido %b esperado 00",
                             {barramento.CAIXA_COMPLETA, barramento.PARAR_ESTEIRA});
                end
                passo(1'b0, 1'b0);
                passo(1'b0, 1'b0);
            end
        end
        $display("test_enchimento done: contagem %0d", barramento.CONTAGEM_GARRAFAS);
    endtask

    task automatic test_troca();
        passo(1'b0, 1'b1);
        n_checks++;
        if ({barramento.CAIXA_COMPLETA, barramento.PARAR_ESTEIRA, barramento.TOTAL_UNI} !== 6'b01_0001) begin
            n_fail++;
            $display("FAIL troca_pedido: obtido %b esperado 010001",
                     {barramento.CAIXA_COMPLETA, barramento.PARAR_ESTEIRA, barramento.TOTAL_UNI});
        end
        for (int i = 0; i < 3; i++) passo(1'b0, 1'b1);
        n_checks++;
        if (barramento.PARAR_ESTEIRA !== 1'b1) begin
            n_fail++;
            $display("FAIL troca_espera: obtido %b esperado 1", barramento.PARAR_ESTEIRA);
        end
        passo(1'b0, 1'b0);
        n_checks++;
        if ({barramento.PARAR_ESTEIRA, barramento.CONTAGEM_GARRAFAS} !== 5'b0_0000) begin
            n_fail++;
            $display("FAIL troca_liberada: obtido %b esperado 00000",
                     {barramento.PARAR_ESTEIRA, barramento.CONTAGEM_GARRAFAS});
        end
        $display("test_troca done: total %0d%0d", barramento.TOTAL_DEZ, barramento.TOTAL_UNI);
    endtask

    task automatic test_fila();
        int pend_esp, cont_esp;
        bit erro_esp;
`ifdef FILA_ESPERA_EN
        pend_esp = 2; cont_esp = 3; erro_esp = 1'b0;
`else
        pend_esp = 0; cont_esp = 1; erro_esp = 1'b1;
`endif
        aplica_reset();
        enche_caixa();
        passo(1'b0, 1'b1);
        passo(1'b1, 1'b1);
        passo(1'b1, 1'b1);
        n_checks++;
        if (barramento.PENDENTES !== 2'(pend_esp)) begin
            n_fail++;
            $display("FAIL fila_pendentes: obtido %0d esperado %0d", barramento.PENDENTES, pend_esp);
        end
        passo(1'b1, 1'b0);
        n_checks++;
        if ({barramento.CONTAGEM_GARRAFAS, barramento.PENDENTES, barramento.ERRO_PERDA}
                !== {4'(cont_esp), 2'd0, erro_esp}) begin
            n_fail++;
            $display("FAIL fila_retorno: obtido cont %0d pend %0d erro %b esperado cont %0d pend 0 erro %b",
                     barramento.CONTAGEM_GARRAFAS, barramento.PENDENTES, barramento.ERRO_PERDA,
                     cont_esp, erro_esp);
        end
        $display("test_fila done: contagem %0d", barramento.CONTAGEM_GARRAFAS);
    endtask

    task automatic test_overflow();
        int pend_esp;
        bit erro_esp;
        aplica_reset();
        enche_caixa();
        for (int k = 1; k <= 4; k++) begin
            passo(1'b1, 1'b0);
`ifdef FILA_ESPERA_EN
            pend_esp = (k < PMAX) ? k : PMAX;
            erro_esp = (k > PMAX);
`else
            pend_esp = 0;
            erro_esp = 1'b1;
`endif
            n_checks++;
            if ({barramento.PENDENTES, barramento.ERRO_PERDA} !== {2'(pend_esp), erro_esp}) begin
                n_fail++;
                $display("FAIL overflow_%0d: obtido pend %0d erro %b esperado pend %0d erro %b", k,
                         barramento.PENDENTES, barramento.ERRO_PERDA, pend_esp, erro_esp);
            end
        end
        passo(1'b0, 1'b1);
        passo(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) passo(1'b0, 1'b0);
        n_checks++;
        if (barramento.ERRO_PERDA !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: obtido %b esperado 1", barramento.ERRO_PERDA);
        end
        aplica_reset();
        #1;
        n_checks++;
        if (barramento.ERRO_PERDA !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_reset: obtido %b esperado 0", barramento.ERRO_PERDA);
        end
        $display("test_overflow done");
    endtask

    task automatic test_total_cem();
        int b;
        aplica_reset();
        for (int caixa = 1; caixa <= 100; caixa++) begin
            enche_caixa();
            passo(1'b0, 1'b1);
            b = caixa % 100;
            n_checks++;
            if ({barramento.TOTAL_DEZ, barramento.TOTAL_UNI} !== {4'(b / 10), 4'(b % 10)}) begin
                n_fail++;
                $display("FAIL total_caixa_%0d: obtido %h esperado %0d%0d", caixa,
                         {barramento.TOTAL_DEZ, barramento.TOTAL_UNI}, b / 10, b % 10);
            end
            n_checks++;
            if (barramento.TOTAL_DEZ > 4'd9 || barramento.TOTAL_UNI > 4'd9) begin
                n_fail++;
                $display("FAIL total_digito_%0d: obtido %h esperado digitos <= 9", caixa,
                         {barramento.TOTAL_DEZ, barramento.TOTAL_UNI});
            end
            passo(1'b0, 1'b0);
            $display("caixa %0d total %0d%0d", caixa, barramento.TOTAL_DEZ, barramento.TOTAL_UNI);
        end
    endtask

    task automatic test_reset_assincrono();
        aplica_reset();
        enche_caixa();
        passo(1'b0, 1'b1);
        passo(1'b1, 1'b1);
        passo(1'b1, 1'b1);
        n_checks++;
        if (barramento.PARAR_ESTEIRA !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_assinc_troca: obtido %b esperado 1", barramento.PARAR_ESTEIRA);
        end
        // Clock is high here; no rising edge occurs before the check below.
        #2;
        RESET = 1'b1;
        modelo_reset();
        #1;
        n_checks++;
        if (observado() !== esperado()) begin
            n_fail++;
            $display("FAIL reset_assinc: obtido %h esperado %h", observado(), esperado());
        end
        @(negedge CLOCK);
        barramento.INCREMENTA_DUZIA = 1'b0;
        barramento.CAIXA_TROCADA    = 1'b0;
        RESET = 1'b0;
        $display("test_reset_assincrono done");
    endtask

    task automatic test_aleatorio();
        bit p, t;
        int erros_locais;
        erros_locais = 0;
        t = 1'b0;
        aplica_reset();
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 3) == 0);
            case (m_fase)
                1:       if ($urandom_range(0, 2) == 0) t = 1'b1;
                2:       if ($urandom_range(0, 2) == 0) t = 1'b0;
                default: t = 1'b0;
            endcase
            passo(p, t);
            n_checks++;
            if (observado() !== esperado()) begin
                n_fail++;
                erros_locais++;
                if (erros_locais <= 10)
                    $display("FAIL aleatorio_ciclo_%0d: obtido %h esperado %h", i, observado(), esperado());
            end
            if (m_erro && $urandom_range(0, 199) == 0) aplica_reset();
        end
        $display("test_aleatorio done: total %0d", m_total);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_enchimento();
        test_troca();
        test_fila();
        test_overflow();
        test_total_cem();
        test_reset_assincrono();
        test_aleatorio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_duzias.md
# contador_duzias

Packing-end counter for the bottling line. It consumes the single-cycle approval pulses from the quality stage and fills a box of GARRAFAS_POR_CAIXA bottles. When a box is full it requests a swap from the box handler with a two-phase level handshake and holds the conveyor while the swap runs. It keeps a two-digit BCD count of completed boxes for the front-panel display.

## Interface
- GARRAFAS_POR_CAIXA, 12, bottles per box; legal range 4..15.
- PENDENTES_MAX, 3, depth of the wait queue for bottles approved during a swap; legal range 1..3.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high; clears all state.
- INCREMENTA_DUZIA  in  1  approval pulse; each high cycle counts as one bottle.
- CAIXA_TROCADA  in  1  swap acknowledge level from the box handler.
- CONTAGEM_GARRAFAS  out  4  bottles in the current box, 0..GARRAFAS_POR_CAIXA.
- CAIXA_COMPLETA  out  1  swap request; high in state CHEIA.
- PARAR_ESTEIRA  out  1  conveyor hold; high in states CHEIA and TROCANDO.
- PENDENTES  out  2  bottles queued during a swap.
- TOTAL_DEZ  out  4  completed boxes, BCD tens digit.
- TOTAL_UNI  out  4  completed boxes, BCD units digit.
- ERRO_PERDA  out  1  sticky flag: a bottle was lost.

## Operation
States and transitions:
- ENCHENDO:
  - A pulse increments CONTAGEM_GARRAFAS.
  - A pulse while the count equals GARRAFAS_POR_CAIXA-1 makes the count GARRAFAS_POR_CAIXA and moves to CHEIA.
- CHEIA:
  - Waits for CAIXA_TROCADA=1, then moves to TROCANDO.
  - The same transition increments the BCD total. Units 9 rolls to 0 with a carry into the tens; a total of 99 wraps to 00.
- TROCANDO:
  - Waits for CAIXA_TROCADA=0, then returns to ENCHENDO.
  - On return, CONTAGEM_GARRAFAS is loaded with PENDENTES, plus 1 if a pulse arrives in that same cycle. PENDENTES is cleared.
- Queueing during a swap:
  - In CHEIA or TROCANDO, a pulse increments PENDENTES.
  - If PENDENTES already equals PENDENTES_MAX, the pulse is dropped and ERRO_PERDA is set.
- CAIXA_TROCADA already high on entry to CHEIA is accepted. The FSM moves to TROCANDO on the next edge, so the handler must return it to 0 before the next box completes.
- ERRO_PERDA stays high until RESET.
- An unused state encoding recovers to ENCHENDO on the next edge.

## Timing
- Reset values: state ENCHENDO, CONTAGEM_GARRAFAS=0, PENDENTES=0, TOTAL_DEZ=0, TOTAL_UNI=0, CAIXA_COMPLETA=0, PARAR_ESTEIRA=0, ERRO_PERDA=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Latency:
  - A pulse on edge k is reflected in the count after edge k.
  - CAIXA_COMPLETA and PARAR_ESTEIRA rise in the cycle after the filling pulse.
- Handshake:
  - CAIXA_COMPLETA falls one cycle after CAIXA_TROCADA is sampled high.
  - PARAR_ESTEIRA falls one cycle after CAIXA_TROCADA is sampled low in TROCANDO.
  - The minimum swap is 2 cycles in the stop state.
- An asynchronous RESET in the middle of a swap drops the pending bottles and the request immediately. The total is also cleared.

## Configuration
- FILA_ESPERA_EN defined: the queue operates as described above.
- FILA_ESPERA_EN undefined:
  - There is no queue and PENDENTES is tied to 0.
  - Any pulse in CHEIA or TROCANDO is dropped and sets ERRO_PERDA.
  - On return to ENCHENDO, the count loads 0, or 1 if a pulse arrives in that same cycle.

## Test plan
- Reset, then 12 pulses spaced 3 cycles apart -> CONTAGEM_GARRAFAS runs 1..12. CAIXA_COMPLETA=1 and PARAR_ESTEIRA=1 one cycle after the 12th pulse.
- From CHEIA: raise CAIXA_TROCADA for 4 cycles, then lower it -> CAIXA_COMPLETA drops after 1 cycle and TOTAL_UNI=1. After release, PARAR_ESTEIRA=0 and the count is 0.
- Queue (FILA_ESPERA_EN defined): 2 pulses during TROCANDO, plus a pulse in the release cycle -> PENDENTES=2, and the count is 3 after the return. ERRO_PERDA=0.
- Overflow: 4 pulses during CHEIA with PENDENTES_MAX=3 -> PENDENTES=3 and ERRO_PERDA=1, held until RESET. Without the macro, the first such pulse sets ERRO_PERDA.
- 100 full box cycles -> the total steps 09->10 and 99->00, with the BCD digits never exceeding 9.
- Assert RESET while in TROCANDO with PENDENTES=2 -> all outputs return to their reset values immediately, without waiting for a clock edge.
